// File: rtl/adc_feeder_pkg.sv
// Shared constants for the ADC sample feeder: data widths, FSM encoding
// and a saturating increment for the drop counter.
package adc_feeder_pkg;

    localparam int ADC_W  = 21;
    localparam int DROP_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Single-clock sample FIFO with a registered occupancy count. The caller only
// asserts push when there is room (or a pop frees a slot in the same cycle).
module adc_sample_fifo
    import adc_feeder_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = ADC_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // NOTE: the storage array has no reset; stale entries are never read
    // because level gates every pop, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (level == FULL_LEVEL);
    assign empty = (level == '0);

endmodule

// File: rtl/adc_sample_feeder.sv
// Queues free-running ADC samples and hands them one at a time to the
// iterative correction engine, holding each sample stable until the next pop.
module adc_sample_feeder
    import adc_feeder_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 63,
    parameter int MIN_GAP = 1
) (
    input  logic                     sys_clk_i,
    input  logic                     reset_i,
    input  logic [ADC_W-1:0]         adc_data_i,
    input  logic                     adc_valid_i,
    input  logic                     engine_srdyo_i,
    input  logic                     clear_flags_i,
    output logic [ADC_W-1:0]         adc_correction_in,
    output logic                     srdyi,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic                     overflow_o,
    output logic [DROP_W-1:0]        drop_count_o,
    output logic                     timeout_o
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0] GAP_LAST  = 3'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
    // With no gap configured the FSM returns straight to IDLE after WAIT.
    localparam logic [1:0] ST_AFTER  = (MIN_GAP > 0) ? ST_GAP : ST_IDLE;

    logic [1:0]       state;
    logic [7:0]       wait_cnt;
    logic [2:0]       gap_cnt;
    logic [ADC_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             push;
    logic             drop;
    logic             timed_out;

    // Pop decision uses the pre-push level, so a sample written this cycle waits one cycle.
    assign pop       = (state == ST_IDLE) && !fifo_empty;
    assign push      = adc_valid_i && (!fifo_full || pop);
    assign drop      = adc_valid_i && !push;
    assign timed_out = (state == ST_WAIT) && !engine_srdyo_i && (wait_cnt == WAIT_LAST);

    adc_sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADC_W)
    ) u_fifo (
        .clk   (sys_clk_i),
        .reset (reset_i),
        .push  (push),
        .pop   (pop),
        .wdata (adc_data_i),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level_o)
    );

    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            state             <= ST_IDLE;
            wait_cnt          <= '0;
            gap_cnt           <= '0;
            adc_correction_in <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        adc_correction_in <= head;
                        state             <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (engine_srdyo_i || timed_out) begin
                        gap_cnt <= '0;
                        state   <= ST_AFTER;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A clear coinciding with a drop still records that one drop.
    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            overflow_o   <= 1'b0;
            timeout_o    <= 1'b0;
            drop_count_o <= '0;
        end else if (clear_flags_i) begin
            overflow_o   <= drop;
            timeout_o    <= 1'b0;
            drop_count_o <= DROP_W'(drop);
        end else begin
            if (drop) begin
                overflow_o   <= 1'b1;
                drop_count_o <= sat_inc(drop_count_o);
            end
            if (timed_out) begin
                timeout_o <= 1'b1;
            end
        end
    end

    assign srdyi  = (state == ST_ISSUE);
    assign busy_o = (state == ST_ISSUE) || (state == ST_WAIT);

endmodule

// File: doc/adc_sample_feeder.md
Name: adc_sample_feeder

Overview:
- Upstream stage of adc_correction_engine. Buffers free-running 21-bit ADC samples in a small FIFO.
- Releases one sample at a time to the engine, because the engine is iterative and takes many cycles per sample.
- Holds adc_correction_in stable for the whole correction. The engine's section comparator reads that input combinationally throughout the computation.
- Reports overflow and engine-timeout status.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- TIMEOUT, 63, max cycles in WAIT before abandoning a sample; 1..255.
- MIN_GAP, 1, idle cycles after engine completion before the next issue; 0..7.

Ports:
- sys_clk_i  in  1  system clock, rising edge.
- reset_i  in  1  synchronous, active-high reset.
- adc_data_i  in  21  raw ADC sample, forwarded unmodified.
- adc_valid_i  in  1  sample strobe, one cycle per sample.
- engine_srdyo_i  in  1  engine completion pulse (engine srdyo).
- clear_flags_i  in  1  clears the sticky flags and drop_count.
- adc_correction_in  out  21  sample presented to the engine.
- srdyi  out  1  one-cycle start pulse to the engine.
- busy_o  out  1  high while a sample is in flight (ISSUE or WAIT).
- fifo_level_o  out  $clog2(DEPTH)+1  current occupancy.
- overflow_o  out  1  sticky: a sample was dropped.
- drop_count_o  out  8  dropped-sample count, saturating at 255.
- timeout_o  out  1  sticky: the engine failed to respond within TIMEOUT.

Behaviour:
- Reset values: all outputs 0; FIFO empty; pointers 0; FSM in IDLE; gap counter 0. Reset mid-operation abandons the in-flight sample and discards FIFO contents.
- Write rule: when adc_valid_i=1, write if level<DEPTH, or if level==DEPTH and a pop occurs in the same cycle.
  - Otherwise drop the sample: set overflow_o, increment drop_count_o (saturating).
- Pop rule: a pop occurs only on the IDLE->ISSUE transition.
  - Simultaneous push and pop leaves level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, GAP.
  - IDLE: if level>0 (pre-push value), pop the head into the hold register (adc_correction_in), then go to ISSUE. A sample written this cycle is not visible until the next cycle.
  - ISSUE: srdyi=1 for exactly this cycle; clear the timeout counter; go to WAIT.
  - WAIT: on engine_srdyo_i=1, go to GAP (or IDLE if MIN_GAP=0). If the timeout counter reaches TIMEOUT without a response, set timeout_o and go to GAP. Otherwise increment the counter.
  - GAP: count MIN_GAP cycles, then go to IDLE.
- Sample-to-srdyi latency: a sample written into an empty FIFO while in IDLE gives srdyi 2 cycles after the write cycle.
- Back-to-back sample issue (srdyi to srdyi): done cycle + MIN_GAP + 2.
- adc_correction_in changes only on a pop and otherwise holds its value, including after completion.
- engine_srdyo_i arriving in IDLE, ISSUE or GAP is ignored (spurious).
- clear_flags_i clears overflow_o, timeout_o and drop_count_o. If a new drop occurs in the same cycle, the clear wins for the flags and drop_count becomes 1, overflow stays set.
- busy_o = (state==ISSUE || state==WAIT).
- fifo_level_o is registered and reflects the post-update occupancy.

Decomposition:
- Shared package adc_feeder_pkg: ADC_W=21, the state encoding (IDLE=0, ISSUE=1, WAIT=2, GAP=3), and DROP_W=8.
- One sub-module, adc_sample_fifo: synchronous single-clock FIFO with push/pop, full/empty and level outputs, and same-cycle push+pop when full.
- The FSM, counters and flags live in adc_sample_feeder.

Test Plan:
- Single sample: write 21'h0ABCD in IDLE with the engine responding 20 cycles after srdyi, MIN_GAP=1.
  - srdyi pulses 2 cycles after the write; adc_correction_in=21'h0ABCD held until the next pop.
  - busy_o high for 21 cycles; fifo_level_o returns to 0.
- Burst of 5 samples on consecutive cycles, engine responding after 10 cycles.
  - Samples are issued in order; each srdyi comes MIN_GAP+2 cycles after the preceding engine_srdyo_i.
  - fifo_level_o peaks at 4.
- Overflow: with the engine stalled in WAIT, write DEPTH+3 = 19 samples.
  - DEPTH accepted, 3 dropped: overflow_o=1, drop_count_o=3.
  - Pulsing clear_flags_i returns overflow_o=0 and drop_count_o=0.
- Timeout: issue one sample and never assert engine_srdyo_i.
  - timeout_o rises TIMEOUT+1 cycles after srdyi.
  - The next queued sample is issued after GAP.
- Full plus simultaneous pop: fill the FIFO to full, then write in the same cycle the FSM pops.
  - The write is accepted; no drop; level stays DEPTH.
- Reset mid-WAIT with 3 samples queued, reset_i held 1 cycle.
  - All outputs 0 on the next cycle; a late engine_srdyo_i is ignored; no srdyi until a new write.
